line_feeder: RTL and testbench

LINE_FEEDER -- requirements
Module: line_feeder

---
 rtl/conv_pkg.sv | 32 +++
 rtl/line_row_buf.sv | 40 ++++
 rtl/line_feeder.sv | 173 +++++++++++++++++
 tb/tb_line_feeder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Package  : conv_pkg
// Purpose  : Image geometry, feeder state encoding and stride codes shared by
//            the line feeder and the convolve engine.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

   localparam int BIT_DEPTH = 8;
   localparam int IMG_W     = 28;
   localparam int IMG_H     = 28;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FILL   = 3'd1,
      ST_SERVE  = 3'd2,
      ST_REFILL = 3'd3,
      ST_DONE   = 3'd4
   } feed_state_t;

   localparam logic [1:0] c_stride_2 = 2'd2;

   // Modulo-3 add used to rotate among the three row buffers.
   function automatic logic [1:0] rot3_add(input logic [1:0] a, input logic [1:0] b);
      logic [2:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/line_row_buf.sv
`default_nettype none
// ============================================================================
// Module   : line_row_buf
// Purpose  : One image row of storage with a write port and a registered read
//            port that can be forced to zero.
// Revision : 1.0 - initial release
// ============================================================================
module line_row_buf #(
   parameter  int BIT_DEPTH = 8,
   parameter  int IMG_W     = 28,
   localparam int AW        = $clog2(IMG_W)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_wr_en,
   input  logic [AW-1:0]        i_wr_addr,
   input  logic [BIT_DEPTH-1:0] i_wr_data,
   input  logic [AW-1:0]        i_rd_addr,
   input  logic                 i_rd_clr,
   output logic [BIT_DEPTH-1:0] o_rd_data
);

   logic [BIT_DEPTH-1:0] r_mem [IMG_W];

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || i_rd_clr) begin
         o_rd_data <= '0;
      end else begin
         o_rd_data <= r_mem[i_rd_addr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/line_feeder.sv
`default_nettype none
// ============================================================================
// Module   : line_feeder
// Purpose  : Loads a raster image into three rotating row buffers and serves
//            it column by column as 3-row strips with stride 1 or 2.
// Revision : 1.0 - initial release
// ============================================================================
module line_feeder
   import conv_pkg::*;
#(
   parameter int BIT_DEPTH = conv_pkg::BIT_DEPTH,
   parameter int IMG_W     = conv_pkg::IMG_W,
   parameter int IMG_H     = conv_pkg::IMG_H
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           stride,
   input  logic [BIT_DEPTH-1:0] pix_in,
   input  logic                 pix_valid,
   output logic                 pix_ready,
   input  logic                 shift_buffer,
   input  logic                 row_done,
   output logic [BIT_DEPTH-1:0] out_l1,
   output logic [BIT_DEPTH-1:0] out_l2,
   output logic [BIT_DEPTH-1:0] out_l3,
   output logic                 strip_ready,
   output logic [4:0]           strip_row,
   output logic                 frame_done
);

   localparam int              AW         = $clog2(IMG_W);
   localparam logic [AW-1:0]   c_last_col = AW'(IMG_W - 1);
   localparam logic [5:0]      c_last_top = 6'(IMG_H - 3);

   feed_state_t          r_state, w_state_nxt;
   logic [1:0]           r_stride_amt;
   logic [4:0]           r_strip_row;
   logic [AW-1:0]        r_col, w_col_nxt;
   logic                 r_blank, w_blank_nxt;
   logic [AW-1:0]        r_fill_col;
   logic [1:0]           r_fill_row;
   logic [1:0]           r_base;
   logic                 w_xfer;
   logic                 w_fill_end;
   logic [1:0]           w_fill_last_row;
   logic [5:0]           w_next_top;
   logic [1:0]           w_wr_sel;
   logic                 w_rd_clr;
   logic [BIT_DEPTH-1:0] w_rd_data [3];

   assign pix_ready   = (r_state == ST_FILL) || (r_state == ST_REFILL);
   assign strip_ready = (r_state == ST_SERVE);
   assign frame_done  = (r_state == ST_DONE);
   assign strip_row   = r_strip_row;

   assign w_xfer          = pix_ready && pix_valid;
   assign w_fill_last_row = (r_state == ST_FILL) ? 2'd2 : (r_stride_amt - 2'd1);
   assign w_fill_end      = w_xfer && (r_fill_col == c_last_col) && (r_fill_row == w_fill_last_row);
   assign w_next_top      = {1'b0, r_strip_row} + {4'd0, r_stride_amt};
   assign w_wr_sel        = rot3_add(r_base, r_fill_row);
   // Output registers are zeroed whenever the next cycle is not a valid column.
   assign w_rd_clr        = (w_state_nxt != ST_SERVE) || w_blank_nxt;

   always_comb begin
      w_state_nxt = r_state;
      w_col_nxt   = r_col;
      w_blank_nxt = r_blank;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_FILL;
            end
         end
         ST_FILL, ST_REFILL: begin
            if (w_fill_end) begin
               w_state_nxt = ST_SERVE;
               w_col_nxt   = '0;
               w_blank_nxt = 1'b0;
            end
         end
         ST_SERVE: begin
            if (row_done) begin
               w_state_nxt = (w_next_top > c_last_top) ? ST_DONE : ST_REFILL;
            end else if (shift_buffer) begin
               if (r_col == c_last_col) begin
                  w_blank_nxt = 1'b1;
               end else begin
                  w_col_nxt = r_col + AW'(1);
               end
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_col        <= '0;
         r_blank      <= 1'b0;
         r_fill_col   <= '0;
         r_fill_row   <= '0;
         r_base       <= '0;
         r_strip_row  <= '0;
         r_stride_amt <= 2'd1;
      end else begin
         r_state <= w_state_nxt;
         r_col   <= w_col_nxt;
         r_blank <= w_blank_nxt;
         if ((r_state == ST_IDLE) && start) begin
            r_stride_amt <= (stride == c_stride_2) ? 2'd2 : 2'd1;
            r_strip_row  <= '0;
            r_fill_col   <= '0;
            r_fill_row   <= '0;
            r_base       <= '0;
         end
         if (w_xfer) begin
            if (r_fill_col == c_last_col) begin
               r_fill_col <= '0;
               r_fill_row <= w_fill_end ? 2'd0 : (r_fill_row + 2'd1);
            end else begin
               r_fill_col <= r_fill_col + AW'(1);
            end
         end
         // Oldest rows were overwritten, so the strip top moves forward by the stride.
         if ((r_state == ST_REFILL) && w_fill_end) begin
            r_base <= rot3_add(r_base, r_stride_amt);
         end
         if ((r_state == ST_SERVE) && row_done && (w_state_nxt == ST_REFILL)) begin
            r_strip_row <= w_next_top[4:0];
         end
      end
   end

   for (genvar g = 0; g < 3; g++) begin : g_row_buf
      line_row_buf #(
         .BIT_DEPTH (BIT_DEPTH),
         .IMG_W     (IMG_W)
      ) u_buf (
         .clk       (clk),
         .rst       (rst),
         .i_wr_en   (w_xfer && (w_wr_sel == 2'(g))),
         .i_wr_addr (r_fill_col),
         .i_wr_data (pix_in),
         .i_rd_addr (w_col_nxt),
         .i_rd_clr  (w_rd_clr),
         .o_rd_data (w_rd_data[g])
      );
   end

   always_comb begin
      out_l1 = w_rd_data[0];
      out_l2 = w_rd_data[1];
      out_l3 = w_rd_data[2];
      case (r_base)
         2'd1: begin
            out_l1 = w_rd_data[1];
            out_l2 = w_rd_data[2];
            out_l3 = w_rd_data[0];
         end
         2'd2: begin
            out_l1 = w_rd_data[2];
            out_l2 = w_rd_data[0];
            out_l3 = w_rd_data[1];
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_line_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_feeder
// Purpose  : Directed bench for line_feeder with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_feeder;

   localparam int BIT_DEPTH = 8;
   localparam int IMG_W     = 28;
   localparam int IMG_H     = 28;
   localparam int P_IDLE    = 0;
   localparam int P_LOAD    = 1;
   localparam int P_SERVE   = 2;
   localparam int P_DONE    = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [1:0]           stride;
   logic [BIT_DEPTH-1:0] pix_in;
   logic                 pix_valid;
   logic                 pix_ready;
   logic                 shift_buffer;
   logic                 row_done;
   logic [BIT_DEPTH-1:0] out_l1;
   logic [BIT_DEPTH-1:0] out_l2;
   logic [BIT_DEPTH-1:0] out_l3;
   logic                 strip_ready;
   logic [4:0]           strip_row;
   logic                 frame_done;

   line_feeder #(
      .BIT_DEPTH (BIT_DEPTH),
      .IMG_W     (IMG_W),
      .IMG_H     (IMG_H)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stride       (stride),
      .pix_in       (pix_in),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .shift_buffer (shift_buffer),
      .row_done     (row_done),
      .out_l1       (out_l1),
      .out_l2       (out_l2),
      .out_l3       (out_l3),
      .strip_ready  (strip_ready),
      .strip_row    (strip_row),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   int   pat      = 0;
   int   feed_idx = 0;
   int   m_phase  = P_IDLE;
   int   m_need   = 0;
   int   m_top    = 0;
   int   m_stride = 1;
   int   m_col    = 0;
   bit   m_blank  = 1'b0;
   int   n_xfer   = 0;
   int   n_rise   = 0;
   int   n_fdone  = 0;
   logic prev_ready = 1'b0;

   function automatic int img(input int p, input int r, input int c);
      if (p == 0) return (r * IMG_W + c) % 256;
      return (r * 13 + c * 5 + 7) % 256;
   endfunction

   function automatic int pix_of(input int p, input int idx);
      return img(p, idx / IMG_W, idx % IMG_W);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Frame-level model: counts pixels per phase and tracks strip top / column.
   always @(posedge clk) begin
      if (!rst) begin
         m_phase <= P_IDLE;
         m_top   <= 0;
         m_col   <= 0;
         m_blank <= 1'b0;
      end else begin
         case (m_phase)
            P_IDLE: if (start) begin
               m_stride <= (stride == 2'd2) ? 2 : 1;
               m_top    <= 0;
               m_need   <= 3 * IMG_W;
               m_phase  <= P_LOAD;
            end
            P_LOAD: if (pix_valid) begin
               m_need <= m_need - 1;
               if (m_need == 1) begin
                  m_phase <= P_SERVE;
                  m_col   <= 0;
                  m_blank <= 1'b0;
               end
            end
            P_SERVE: if (row_done) begin
               if (m_top + m_stride > IMG_H - 3) begin
                  m_phase <= P_DONE;
               end else begin
                  m_top   <= m_top + m_stride;
                  m_need  <= m_stride * IMG_W;
                  m_phase <= P_LOAD;
               end
            end else if (shift_buffer) begin
               if (m_col == IMG_W - 1) m_blank <= 1'b1;
               else                    m_col   <= m_col + 1;
            end
            default: m_phase <= P_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      if (pix_valid && pix_ready) n_xfer++;
      if (strip_ready && !prev_ready) n_rise++;
      prev_ready = strip_ready;
      if (frame_done) n_fdone++;
      check("pix_ready", pix_ready, m_phase == P_LOAD);
      check("strip_ready", strip_ready, m_phase == P_SERVE);
      check("frame_done", frame_done, m_phase == P_DONE);
      check("strip_row", strip_row, m_top);
      if (m_phase == P_SERVE) begin
         check("out_l1", out_l1, m_blank ? 0 : img(pat, m_top,     m_col));
         check("out_l2", out_l2, m_blank ? 0 : img(pat, m_top + 1, m_col));
         check("out_l3", out_l3, m_blank ? 0 : img(pat, m_top + 2, m_col));
      end
   end

   task automatic feed_step(input bit toggle, input int n);
      bit xfer;
      @(negedge clk);
      xfer = pix_valid && pix_ready;
      @(posedge clk);
      #1;
      start        = 1'b0;
      row_done     = 1'b0;
      shift_buffer = 1'b0;
      if (xfer) begin
         feed_idx++;
         pix_in = 8'(pix_of(pat, feed_idx));
      end
      pix_valid = toggle ? n[0] : 1'b1;
   endtask

   task automatic run_load(input bit toggle, output int n);
      n = 0;
      do begin
         n++;
         feed_step(toggle, n);
      end while (!strip_ready && n < 400);
      check("load_timeout", strip_ready, 1);
   endtask

   task automatic start_frame(input logic [1:0] s, input int p);
      pat       = p;
      feed_idx  = 0;
      pix_in    = 8'(pix_of(p, 0));
      stride    = s;
      start     = 1'b1;
      pix_valid = 1'b1;
   endtask

   task automatic shift_n(input int n);
      if (n > 0) begin
         shift_buffer = 1'b1;
         repeat (n) @(posedge clk);
         #1;
         shift_buffer = 1'b0;
      end
   endtask

   task automatic end_strip(input bit with_shift);
      row_done     = 1'b1;
      shift_buffer = with_shift;
      @(posedge clk);
      #1;
      row_done     = 1'b0;
      shift_buffer = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string name, input int a, input int b, input int c);
      check({name, "_l1"}, out_l1, a);
      check({name, "_l2"}, out_l2, b);
      check({name, "_l3"}, out_l3, c);
   endtask

   initial begin
      int n;
      int base_rise;
      int base_fd;
      int base_xfer;
      rst = 1'b0; start = 1'b0; stride = 2'd0; pix_in = '0;
      pix_valid = 1'b0; shift_buffer = 1'b0; row_done = 1'b0;
      idle(3);
      check("rst_pix_ready", pix_ready, 0);
      check("rst_strip_ready", strip_ready, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_strip_row", strip_row, 0);
      check_outs("rst", 0, 0, 0);
      rst = 1'b1;
      idle(1);

      // Stride 1 frame, ramp pattern
      base_rise = n_rise;
      base_fd   = n_fdone;
      start_frame(2'd1, 0);
      run_load(1'b0, n);
      check("fill_latency", n, 85);
      check_outs("strip0_col0", 0, 28, 56);
      shift_n(5);
      check_outs("strip0_col5", 5, 33, 61);
      end_strip(1'b0);
      run_load(1'b0, n);
      check("strip1_row", strip_row, 1);
      check_outs("strip1_col0", 28, 56, 84);
      shift_n(27);
      check_outs("strip1_col27", 55, 83, 111);
      shift_n(3);
      check_outs("strip1_past_end", 0, 0, 0);
      end_strip(1'b1);
      check("both_ends_strip", strip_ready, 0);
      run_load(1'b0, n);
      check("strip2_row", strip_row, 2);
      check_outs("strip2_col0", 56, 84, 112);
      for (int s = 2; s < 25; s++) begin
         shift_n(s % 5);
         if (s == 7) begin
            start  = 1'b1;
            stride = 2'd2;
            idle(1);
            start  = 1'b0;
         end
         end_strip(1'b0);
         run_load(1'b0, n);
      end
      check("last_strip_row", strip_row, 25);
      shift_n(4);
      end_strip(1'b0);
      idle(4);
      check("s1_strip_count", n_rise - base_rise, 26);
      check("s1_frame_done_count", n_fdone - base_fd, 1);

      // Throttled fill, odd stride code, then reset in the middle of a refill
      base_fd = n_fdone;
      start_frame(2'd3, 1);
      run_load(1'b1, n);
      check("throttled_latency", n, 168);
      check_outs("throttled_col0", 7, 20, 33);
      end_strip(1'b0);
      for (int i = 1; i <= 10; i++) feed_step(1'b1, i);
      rst = 1'b0;
      idle(1);
      check("mid_rst_pix_ready", pix_ready, 0);
      check("mid_rst_strip_ready", strip_ready, 0);
      check("mid_rst_frame_done", frame_done, 0);
      check("mid_rst_strip_row", strip_row, 0);
      check_outs("mid_rst", 0, 0, 0);
      rst = 1'b1;
      pix_valid = 1'b0;
      idle(5);
      check("mid_rst_no_frame_done", n_fdone - base_fd, 0);

      // Stride 2 full frame
      base_rise = n_rise;
      base_fd   = n_fdone;
      base_xfer = n_xfer;
      start_frame(2'd2, 1);
      run_load(1'b0, n);
      for (int k = 0; k < 13; k++) begin
         check("s2_strip_row", strip_row, 2 * k);
         shift_n(k % 4);
         end_strip(1'b0);
         if (k < 12) run_load(1'b0, n);
      end
      idle(4);
      check("s2_strip_count", n_rise - base_rise, 13);
      check("s2_frame_done_count", n_fdone - base_fd, 1);
      check("s2_pixels_accepted", n_xfer - base_xfer, 3 * IMG_W + 12 * 2 * IMG_W);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
